serial_demux8: RTL and testbench

Clocked 8-bit deserialiser: the receive-side counterpart of the 8-to-1 multiplexer used for parallel-to-serial conversion. It steers a serial bit stream into eight addressable output latches, like a 74259 driven by a 3-bit address counter. A valid/ready handshake paces the input, and a valid/ack handshake presents each completed frame. A direct addressable-write port and a synchronous clear are also provided.

---
 rtl/serial_demux8.sv | 110 +++++++++++
 tb/tb_serial_demux8.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_demux8.sv
// serial_demux8: serial-to-parallel deserialiser steering a bit stream into eight
// addressable latches, with valid/ready input pacing, valid/ack frame hand-off,
// a direct addressable-write port and a synchronous clear.
// Optional even-parity beat per frame: define SERIAL_DEMUX8_PARITY_EN.
module serial_demux8 #(
    parameter int FRAME_BITS = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ser_data_i,
    input  logic       ser_valid_i,
    output logic       ser_ready_o,
    input  logic       wr_en_i,
    input  logic [2:0] wr_addr_i,
    input  logic       wr_data_i,
    input  logic       clear_i,
    output logic [0:7] q_o,
    output logic       q_valid_o,
    input  logic       q_ack_i,
    output logic [2:0] bit_index_o,
    output logic       parity_err_o
);
`ifdef SERIAL_DEMUX8_PARITY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_PARITY = 2'd2, S_HOLD = 2'd3} state_t;
    localparam state_t S_AFTER = S_PARITY;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_HOLD = 2'd3} state_t;
    localparam state_t S_AFTER = S_HOLD;
`endif
    localparam logic [2:0] LAST = 3'(FRAME_BITS - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [0:7] q_q, q_d;
    logic       beat, data_beat;

    assign ser_ready_o = state_q != S_HOLD;
    assign q_valid_o   = state_q == S_HOLD;
    assign bit_index_o = idx_q;
    assign q_o         = q_q;
    assign beat        = ser_valid_i & ser_ready_o;
    assign data_beat   = beat & (state_q == S_IDLE || state_q == S_FILL);

`ifdef SERIAL_DEMUX8_PARITY_EN
    logic par_q, par_d, perr_q, perr_d, par_beat;

    assign par_beat     = beat & (state_q == S_PARITY);
    assign parity_err_o = perr_q;

    // Running XOR of the frame's data bits; the parity beat folds in to give the error flag.
    always_comb begin
        par_d  = par_q;
        perr_d = perr_q;
        if (data_beat) par_d = (state_q == S_IDLE ? 1'b0 : par_q) ^ ser_data_i;
        if (par_beat) perr_d = par_q ^ ser_data_i;
        if (clear_i) begin
            par_d  = 1'b0;
            perr_d = 1'b0;
        end
    end

    // Parity accumulator and held error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

    // Next-state: serial beats fill latches, ack releases the hold, direct writes override, clear wins.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        q_d     = q_q;
        if (data_beat) begin
            q_d[idx_q] = ser_data_i;
            idx_d      = idx_q == LAST ? 3'd0 : idx_q + 3'd1;
            state_d    = idx_q == LAST ? S_AFTER : S_FILL;
        end
`ifdef SERIAL_DEMUX8_PARITY_EN
        if (par_beat) state_d = S_HOLD;
`endif
        if (state_q == S_HOLD && q_ack_i) state_d = S_IDLE;
        if (wr_en_i) q_d[wr_addr_i] = wr_data_i;
        if (clear_i) begin
            state_d = S_IDLE;
            idx_d   = 3'd0;
            q_d     = '0;
        end
    end

    // State, address counter and latch register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            q_q     <= q_d;
        end
    end
endmodule

// File: tb/tb_serial_demux8.sv
// tb_serial_demux8: scoreboard bench for serial_demux8 with a behavioural latch model.
module tb_serial_demux8;
    localparam int FB = 8;

    logic       clk = 1'b0, rst = 1'b1;
    logic       ser_data = 1'b0, ser_valid = 1'b0, wr_en = 1'b0, wr_data = 1'b0, clear = 1'b0, q_ack = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [0:7] q;
    logic       q_valid, ser_ready, parity_err;
    logic [2:0] bit_index;

    logic       d3_ser_data = 1'b0, d3_ser_valid = 1'b0, d3_wr_en = 1'b0, d3_wr_data = 1'b0, d3_clear = 1'b0, d3_q_ack = 1'b0;
    logic [2:0] d3_wr_addr = 3'd0;
    logic [0:7] d3_q;
    logic       d3_q_valid, d3_ser_ready, d3_parity_err;
    logic [2:0] d3_bit_index;

    serial_demux8 #(.FRAME_BITS(FB)) dut (
        .clk_i(clk), .rst_i(rst), .ser_data_i(ser_data), .ser_valid_i(ser_valid), .ser_ready_o(ser_ready),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .clear_i(clear), .q_o(q),
        .q_valid_o(q_valid), .q_ack_i(q_ack), .bit_index_o(bit_index), .parity_err_o(parity_err)
    );

    serial_demux8 #(.FRAME_BITS(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .ser_data_i(d3_ser_data), .ser_valid_i(d3_ser_valid), .ser_ready_o(d3_ser_ready),
        .wr_en_i(d3_wr_en), .wr_addr_i(d3_wr_addr), .wr_data_i(d3_wr_data), .clear_i(d3_clear), .q_o(d3_q),
        .q_valid_o(d3_q_valid), .q_ack_i(d3_q_ack), .bit_index_o(d3_bit_index), .parity_err_o(d3_parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:7] q;
        logic       pe;
    } exp_t;
    exp_t sb[$];

    int         checks = 0, errors = 0;
    logic [0:7] mq = '0;
    int         midx = 0;
    logic       mpar = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every newly presented frame is compared against the oldest expected frame.
    initial begin
        logic vprev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_valid && !vprev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=%0h required=none", q);
                end else begin
                    e = sb.pop_front();
                    chk("frame_q", q, e.q);
                    chk("frame_parity_err", parity_err, e.pe);
                end
            end
            vprev = q_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic gaps(input int gmax);
        repeat ($urandom_range(0, gmax)) begin
            ser_valid = 1'b0;
            ser_data  = 1'($urandom);
            q_ack     = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic data_beat(input logic b, input bit push);
        chk("bit_index", bit_index, midx);
        chk("ready_in_frame", ser_ready, 1);
        ser_valid = 1'b1;
        ser_data  = b;
        q_ack     = 1'($urandom);
        mpar      = (midx == 0 ? 1'b0 : mpar) ^ b;
        mq[midx]  = b;
        midx      = (midx + 1) % FB;
        if (push) sb.push_back('{mq, 1'b0});
        @(negedge clk);
        ser_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [0:7] bits, input int gmax, input int hold, input bit bad);
        for (int i = 0; i < FB; i++) begin
            gaps(gmax);
`ifdef SERIAL_DEMUX8_PARITY_EN
            data_beat(bits[i], 1'b0);
`else
            data_beat(bits[i], i == FB - 1);
`endif
        end
`ifdef SERIAL_DEMUX8_PARITY_EN
        gaps(gmax);
        chk("ready_parity", ser_ready, 1);
        chk("no_valid_before_parity", q_valid, 0);
        ser_valid = 1'b1;
        ser_data  = mpar ^ bad;
        q_ack     = 1'($urandom);
        sb.push_back('{mq, bad});
        @(negedge clk);
        ser_valid = 1'b0;
`endif
        chk("q_valid_rise", q_valid, 1);
        chk("index_wrap", bit_index, 0);
        for (int k = 0; k < hold; k++) begin
            ser_valid = 1'b1;
            ser_data  = 1'($urandom);
            q_ack     = 1'b0;
            @(negedge clk);
            chk("hold_valid", q_valid, 1);
            chk("hold_ready", ser_ready, 0);
            chk("hold_q", q, mq);
        end
        ser_valid = 1'b0;
        q_ack     = 1'b1;
        @(negedge clk);
        q_ack = 1'b0;
        chk("ack_valid", q_valid, 0);
        chk("ack_ready", ser_ready, 1);
        chk("ack_index", bit_index, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_q", q, 0);
        chk("rst_valid", q_valid, 0);
        chk("rst_ready", ser_ready, 1);
        chk("rst_index", bit_index, 0);
        chk("rst_parity_err", parity_err, 0);
        rst = 1'b0;
        @(negedge clk);

        send_frame(8'b10110010, 0, 5, 1'b0);
        send_frame(8'b11100000, 0, 2, 1'b0);
        send_frame(8'b11100000, 1, 2, 1'b1);

        for (int i = 0; i < 4; i++) data_beat(1'($urandom), 1'b0);
        chk("pre_wr_index", bit_index, 4);
        ser_valid = 1'b1;
        ser_data  = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 3'd4;
        wr_data   = 1'b1;
        mq[4]     = 1'b1;
        midx      = 5;
        @(negedge clk);
        ser_valid = 1'b0;
        wr_en     = 1'b0;
        chk("wr_wins_bit", q[4], 1);
        chk("wr_wins_q", q, mq);
        chk("wr_wins_index", bit_index, 5);
        clear     = 1'b1;
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 3'd2;
        @(negedge clk);
        clear     = 1'b0;
        ser_valid = 1'b0;
        wr_en     = 1'b0;
        mq        = '0;
        midx      = 0;
        chk("clear_q", q, 0);
        chk("clear_index", bit_index, 0);
        chk("clear_valid", q_valid, 0);
        chk("clear_ready", ser_ready, 1);
        chk("clear_parity_err", parity_err, 0);

        send_frame(8'b01101001, 0, 1, 1'b1);
        for (int i = 0; i < 6; i++) data_beat(1'b1, 1'b0);
        chk("pre_rst_index", bit_index, 6);
        #2 rst = 1'b1;
        #1;
        chk("arst_q", q, 0);
        chk("arst_valid", q_valid, 0);
        chk("arst_ready", ser_ready, 1);
        chk("arst_index", bit_index, 0);
        chk("arst_parity_err", parity_err, 0);
        @(negedge clk);
        rst  = 1'b0;
        mq   = '0;
        midx = 0;
        send_frame(8'b00110101, 2, 3, 1'b0);

        for (int i = 0; i < 8; i++) begin
            d3_wr_en   = 1'b1;
            d3_wr_addr = 3'(i);
            d3_wr_data = 1'b1;
            @(negedge clk);
        end
        d3_wr_en = 1'b0;
        chk("d3_preset", d3_q, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            chk("d3_index", d3_bit_index, i);
            d3_ser_valid = 1'b1;
            d3_ser_data  = 1'b0;
            @(negedge clk);
        end
`ifdef SERIAL_DEMUX8_PARITY_EN
        @(negedge clk);
`endif
        d3_ser_valid = 1'b0;
        chk("d3_q", d3_q, 8'h1F);
        chk("d3_valid", d3_q_valid, 1);
        chk("d3_index_wrap", d3_bit_index, 0);
        chk("d3_parity_err", d3_parity_err, 0);
        d3_q_ack = 1'b1;
        @(negedge clk);
        d3_q_ack = 1'b0;
        chk("d3_ack_valid", d3_q_valid, 0);

        for (int n = 0; n < 25; n++)
            send_frame(8'($urandom), 3, $urandom_range(0, 4), 1'($urandom));

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
